dadda_share_arb: RTL and testbench
==================================

# dadda_share_arb

Sequencer that time-shares one `dadda_8` unsigned 8x8 multiplier among up to 8 requesters. Each requester submits operands over a valid/ready handshake. The block grants requesters round-robin, registers the operands, captures the combinational product one cycle later, and returns it with the requester ID over a valid/ready response channel. It sits between the issuing units and the single `dadda_8` instance, which it instantiates internally.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  request pending; bit i belongs to requester i.
- `req_a`  in  8*NREQ  operand A; requester i uses bits [8i+7:8i].
- `req_b`  in  8*NREQ  operand B; same packing as `req_a`.
- `req_ready`  out  NREQ  one-hot grant; the handshake for requester i completes when `req_valid[i]` and `req_ready[i]` are both high.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  3  index of the requester that owns the result.
- `rsp_y`  out  16  product A*B, unsigned.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has 3 states: IDLE, MUL, RESP.
- **IDLE**
  - `req_ready` is computed combinationally. The grant goes to the first set `req_valid` bit, searching upward from `ptr` and wrapping from NREQ-1 to 0. At most one bit is set.
  - With no requests, `req_ready` is all zero.
  - On a handshake edge:
    - The selected `req_a`/`req_b` slices go into `op_a`/`op_b`, and the grant index goes into `op_id`.
    - `ptr` becomes (grant+1) mod NREQ.
    - The state moves to MUL.
- **MUL**
  - `dadda_8` is driven from `op_a`/`op_b`.
  - At the next edge, its output goes into `rsp_y` and `op_id` goes into `rsp_id`, and the state moves to RESP.
  - `req_ready` is 0.
- **RESP**
  - `rsp_valid` is 1. `rsp_y` and `rsp_id` stay stable until the result is accepted.
  - On the edge with `rsp_ready` high, the state returns to IDLE.
  - No grant is issued in RESP. `req_ready` is 0.
- **Requester rules**
  - Once `req_valid[i]` is high, requester i holds it and its operands stable until its handshake completes.
  - Deasserting `req_valid` before the grant is legal. No transaction is recorded for that request.
- **Arithmetic**
  - Full 16-bit unsigned product with no truncation. The maximum is 255*255 = 65025 = 16'hFE01.
  - `rsp_y` equals `op_a*op_b` exactly.
- **Reset**, asynchronous, applied in any state:
  - state = IDLE, `ptr` = 0.
  - `op_a`, `op_b`, `op_id`, `rsp_y`, `rsp_id` = 0.
  - `rsp_valid` = 0, `busy` = 0, `req_ready` = 0 while `rst_n` is low.
  - A transaction in flight is discarded and produces no response.
  - After release, arbitration starts from requester 0.
- **Simultaneous events**
  - New requests that arrive during MUL or RESP wait.
  - When the state returns to IDLE, arbitration uses the current `req_valid` and the updated `ptr`.
  - A requester that has just been granted has the lowest priority in the next arbitration.

## Timing
- Request handshake at edge E0 → state MUL in cycle E0..E1.
- Product registered at E1 → `rsp_valid` high from E1.
- Earliest response accept at E2 → IDLE → next grant accepted at E3 at the earliest.
- Minimum occupancy is 3 cycles per transaction, so peak throughput is 1 product per 3 cycles.
- Each cycle of `rsp_ready` low in RESP adds one cycle.
- The combinational path `req_valid` → `req_ready` exists only in IDLE.
- The only combinational path through `dadda_8` is `op_*` → `rsp_y` register, one cycle.
- `busy` is registered. It rises the cycle after a grant and falls the cycle after the response is accepted.

## Test plan
- **Single request:** requester 1 presents A=200, B=255 with `rsp_ready` tied high.
  - `req_ready` = 4'b0010 in the same cycle.
  - `rsp_valid` rises 1 cycle after the grant edge, with `rsp_y` = 51000 and `rsp_id` = 1.
  - `busy` is low again 1 cycle after the response.
- **Round-robin fairness:** all 4 requesters valid continuously, each with distinct operands.
  - Grant order is 0, 1, 2, 3, 0, 1.
  - Each response carries the matching ID and product.
  - Grant edges are exactly 3 cycles apart.
- **Backpressure:** `rsp_ready` held low for 5 cycles during RESP with A=15, B=17.
  - `rsp_valid`, `rsp_y` = 255 and `rsp_id` stay constant throughout.
  - `req_ready` stays 0 throughout.
  - The next grant comes only after the accept edge.
- **Reset mid-operation:** `rst_n` pulsed low while in MUL.
  - All outputs are 0 immediately, with no clock needed.
  - No response ever appears for the dropped request.
  - After release with requesters 2 and 0 both valid, requester 0 is granted first.
- **Corner operands:** 0*123 → 0; 255*255 → 65025; 1*255 → 255; 128*2 → 256.
- **Random regression:** 1000 random transactions on random requesters with random `rsp_ready` stalls.
  - Every `rsp_y` equals A*B of the matching request.
  - No request is lost or duplicated.
  - Per-requester order is preserved.

Source files
------------

// File: rtl/dadda_share_arb.sv
// Round-robin sequencer sharing one dadda_8 multiplier among NREQ requesters.
// Flow per transaction: IDLE (grant) -> MUL (operands registered) -> RESP (hold until accepted).

module dadda_8 (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] y_o
);
    // Dadda column reduction to heights 6,4,3,2, then one final two-row add.
    // All heights depend only on loop structure, so this unrolls to a fixed tree.
    function automatic logic [15:0] dadda_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0][15:0] col;
        logic [15:0][15:0] nxt;
        logic [3:0]        h  [16];
        logic [3:0]        hn [16];
        logic [3:0]        idx;
        logic [15:0]       r0;
        logic [15:0]       r1;
        logic              s;
        logic              cy;
        int                d;
        int                rem;
        int                raw;
        col = '0;
        nxt = '0;
        r0  = '0;
        r1  = '0;
        for (int c = 0; c < 16; c++) begin
            h[c]  = 4'd0;
            hn[c] = 4'd0;
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                col[i+j][h[i+j]] = a[i] & b[j];
                h[i+j] = h[i+j] + 4'd1;
            end
        end
        for (int st = 0; st < 4; st++) begin
            d   = (st == 0) ? 6 : (st == 1) ? 4 : (st == 2) ? 3 : 2;
            nxt = '0;
            for (int c = 0; c < 16; c++) hn[c] = 4'd0;
            for (int c = 0; c < 16; c++) begin
                idx = 4'd0;
                for (int k = 0; k < 8; k++) begin
                    raw = int'(h[c]) - int'(idx);
                    rem = raw + int'(hn[c]);
                    if (rem > d && raw >= 2) begin
                        if (rem == d + 1 || raw == 2) begin
                            s   = col[c][idx] ^ col[c][idx+4'd1];
                            cy  = col[c][idx] & col[c][idx+4'd1];
                            idx = idx + 4'd2;
                        end else begin
                            s   = col[c][idx] ^ col[c][idx+4'd1] ^ col[c][idx+4'd2];
                            cy  = (col[c][idx] & col[c][idx+4'd1]) |
                                  (col[c][idx] & col[c][idx+4'd2]) |
                                  (col[c][idx+4'd1] & col[c][idx+4'd2]);
                            idx = idx + 4'd3;
                        end
                        nxt[c][hn[c]] = s;
                        hn[c] = hn[c] + 4'd1;
                        // Product < 2^16, so a carry out of column 15 is always zero.
                        if (c < 15) begin
                            nxt[c+1][hn[c+1]] = cy;
                            hn[c+1] = hn[c+1] + 4'd1;
                        end
                    end
                end
                for (int k = 0; k < 16; k++) begin
                    if (4'(k) >= idx && 4'(k) < h[c]) begin
                        nxt[c][hn[c]] = col[c][k];
                        hn[c] = hn[c] + 4'd1;
                    end
                end
            end
            col = nxt;
            h   = hn;
        end
        for (int c = 0; c < 16; c++) begin
            r0[c] = col[c][0];
            r1[c] = col[c][1];
        end
        return r0 + r1;
    endfunction

    assign y_o = dadda_mul(a_i, b_i);
endmodule

module dadda_share_arb #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2:0]        rsp_id,
    output logic [15:0]       rsp_y,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, MUL, RESP} state_e;

    state_e      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [7:0]  op_a_q, op_b_q;
    logic [2:0]  op_id_q;
    logic [15:0] rsp_y_q;
    logic [2:0]  rsp_id_q;
    logic        busy_q;
    logic [15:0] prod;
    logic [7:0]  vld8;
    logic [63:0] a64, b64;
    logic [7:0]  gnt_oh;
    logic [3:0]  j;
    logic [2:0]  gnt_idx;
    logic        found;
    logic        hs;

    assign vld8 = 8'(req_valid);
    assign a64  = 64'(req_a);
    assign b64  = 64'(req_b);

    // Search upward from ptr, wrapping at NREQ-1.
    always_comb begin
        found   = 1'b0;
        gnt_idx = 3'd0;
        j       = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            j = {1'b0, ptr_q} + 4'(k);
            if (j >= 4'(NREQ)) j = j - 4'(NREQ);
            if (!found && vld8[j[2:0]]) begin
                found   = 1'b1;
                gnt_idx = j[2:0];
            end
        end
        gnt_oh = found ? (8'd1 << gnt_idx) : 8'd0;
    end

    assign req_ready = (state_q == IDLE && rst_n) ? gnt_oh[NREQ-1:0] : '0;
    assign hs        = |(req_valid & req_ready);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: if (hs) begin
                state_d = MUL;
                ptr_d   = (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
            end
            MUL:  state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= 3'd0;
            op_a_q   <= 8'd0;
            op_b_q   <= 8'd0;
            op_id_q  <= 3'd0;
            rsp_y_q  <= 16'd0;
            rsp_id_q <= 3'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= (state_d != IDLE);
            if (state_q == IDLE && hs) begin
                op_a_q  <= a64[{gnt_idx, 3'b000} +: 8];
                op_b_q  <= b64[{gnt_idx, 3'b000} +: 8];
                op_id_q <= gnt_idx;
            end
            if (state_q == MUL) begin
                rsp_y_q  <= prod;
                rsp_id_q <= op_id_q;
            end
        end
    end

    dadda_8 u_mul (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .y_o (prod)
    );

    assign rsp_valid = (state_q == RESP);
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_dadda_share_arb.sv
// Bench for dadda_share_arb: directed scenarios plus a randomized run against a queue-based model.
module tb_dadda_share_arb;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_a, req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid, rsp_ready;
    logic [2:0]     rsp_id;
    logic [15:0]    rsp_y;
    logic           busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dadda_share_arb #(.NREQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[8*i +: 8] = 8'(a);
        req_b[8*i +: 8] = 8'(b);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = '1; req_a = '1; req_b = '1; rsp_ready = 1'b1;
        #3;
        total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (rsp_y !== 16'd0) begin bad++; $display("FAIL reset_rsp_y got=%0d want=0", rsp_y); end
        total++; if (rsp_id !== 3'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
        tick;
        req_valid = '0;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single;
        do_reset;
        rsp_ready = 1'b1;
        set_op(1, 200, 255); req_valid = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_grant got=%b want=0010", req_ready); end
        tick; req_valid = '0;
        total++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL single_mul busy=%b rsp_valid=%b want 1/0", busy, rsp_valid); end
        tick;
        total++; if (rsp_valid !== 1'b1 || rsp_y !== 16'd51000 || rsp_id !== 3'd1) begin
            bad++; $display("FAIL single_rsp valid=%b y=%0d id=%0d want 1/51000/1", rsp_valid, rsp_y, rsp_id); end
        tick;
        total++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL single_idle busy=%b rsp_valid=%b want 0/0", busy, rsp_valid); end
    endtask

    task automatic test_round_robin;
        int last, g, t, exp_y;
        logic [N-1:0] exp_oh;
        do_reset;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, 10 + i*7, 3 + i*11);
        req_valid = '1;
        #1;
        last = 0;
        for (int n = 0; n < 6; n++) begin
            t = 0;
            while (req_ready == '0 && t < 10) begin tick; t++; end
            g = n % N;
            exp_oh = N'(1) << g;
            total++; if (req_ready !== exp_oh) begin bad++; $display("FAIL rr_grant n=%0d got=%b want=%b", n, req_ready, exp_oh); end
            if (n > 0) begin
                total++; if (cyc - last != 3) begin bad++; $display("FAIL rr_spacing n=%0d got=%0d want=3", n, cyc - last); end
            end
            last = cyc;
            exp_y = (10 + g*7) * (3 + g*11);
            tick; tick;
            total++; if (rsp_valid !== 1'b1 || rsp_id !== 3'(g) || rsp_y !== 16'(exp_y)) begin
                bad++; $display("FAIL rr_rsp n=%0d valid=%b id=%0d y=%0d want 1/%0d/%0d", n, rsp_valid, rsp_id, rsp_y, g, exp_y); end
            tick;
        end
        req_valid = '0;
        tick;
    endtask

    task automatic test_backpressure;
        do_reset;
        rsp_ready = 1'b0;
        set_op(3, 15, 17); req_valid = 4'b1000;
        #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_grant got=%b want=1000", req_ready); end
        tick;
        set_op(0, 2, 3); req_valid = 4'b0001;
        tick;
        for (int k = 0; k < 5; k++) begin
            total++; if (rsp_valid !== 1'b1 || rsp_y !== 16'd255 || rsp_id !== 3'd3) begin
                bad++; $display("FAIL bp_hold k=%0d valid=%b y=%0d id=%0d want 1/255/3", k, rsp_valid, rsp_y, rsp_id); end
            total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL bp_ready k=%0d got=%b want=0000", k, req_ready); end
            tick;
        end
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0 || rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_pre_accept ready=%b valid=%b want 0000/1", req_ready, rsp_valid); end
        tick;
        total++; if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_next_grant ready=%b valid=%b want 0001/0", req_ready, rsp_valid); end
        tick; req_valid = '0;
        tick;
        total++; if (rsp_valid !== 1'b1 || rsp_y !== 16'd6 || rsp_id !== 3'd0) begin
            bad++; $display("FAIL bp_second valid=%b y=%0d id=%0d want 1/6/0", rsp_valid, rsp_y, rsp_id); end
        tick;
    endtask

    task automatic test_reset_mid;
        int got;
        logic [N-1:0] hsv;
        logic [2:0]  r_id [4];
        logic [15:0] r_y  [4];
        do_reset;
        rsp_ready = 1'b1;
        set_op(1, 9, 9); req_valid = 4'b0010;
        tick; req_valid = '0;
        tick; tick;
        set_op(3, 7, 7); req_valid = 4'b1000;
        tick; req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0) begin
            bad++; $display("FAIL rmid_ctrl valid=%b busy=%b ready=%b want 0/0/0000", rsp_valid, busy, req_ready); end
        total++; if (rsp_y !== 16'd0 || rsp_id !== 3'd0) begin bad++; $display("FAIL rmid_data y=%0d id=%0d want 0/0", rsp_y, rsp_id); end
        set_op(0, 3, 4); set_op(2, 5, 6); req_valid = 4'b0101;
        tick; tick;
        rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_first got=%b want=0001", req_ready); end
        got = 0;
        for (int t = 0; t < 12; t++) begin
            hsv = req_valid & req_ready;
            if (rsp_valid && got < 4) begin r_id[got] = rsp_id; r_y[got] = rsp_y; got++; end
            tick;
            req_valid = req_valid & ~hsv;
            #1;
        end
        total++; if (got != 2) begin bad++; $display("FAIL rmid_count got=%0d want=2", got); end
        if (got == 2) begin
            total++; if (r_id[0] !== 3'd0 || r_y[0] !== 16'd12) begin bad++; $display("FAIL rmid_rsp0 id=%0d y=%0d want 0/12", r_id[0], r_y[0]); end
            total++; if (r_id[1] !== 3'd2 || r_y[1] !== 16'd30) begin bad++; $display("FAIL rmid_rsp1 id=%0d y=%0d want 2/30", r_id[1], r_y[1]); end
        end
    endtask

    task automatic test_corners;
        int ca[4] = '{0, 255, 1, 128};
        int cb[4] = '{123, 255, 255, 2};
        int ce[4] = '{0, 65025, 255, 256};
        int t;
        rsp_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            set_op(2, ca[n], cb[n]); req_valid = 4'b0100;
            #1;
            t = 0;
            while (req_ready != 4'b0100 && t < 10) begin tick; t++; end
            total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL corner_grant n=%0d got=%b want=0100", n, req_ready); end
            tick; req_valid = '0;
            tick;
            total++; if (rsp_valid !== 1'b1 || rsp_y !== 16'(ce[n])) begin
                bad++; $display("FAIL corner_y %0d*%0d valid=%b got=%0d want=%0d", ca[n], cb[n], rsp_valid, rsp_y, ce[n]); end
            tick;
        end
    endtask

    typedef struct { int id; int prod; int seq; } txn_t;

    task automatic test_random;
        txn_t q[$];
        txn_t e;
        int pa[N], pb[N], iseq[N], rseq[N];
        int ptr_m, issued, received, age, g, j;
        bit inflight;
        logic [N-1:0] exp_oh, hsv;
        do_reset;
        ptr_m = 0; issued = 0; received = 0; age = 0; inflight = 1'b0;
        for (int i = 0; i < N; i++) begin pa[i] = 0; pb[i] = 0; iseq[i] = 0; rseq[i] = 0; end
        for (int c = 0; c < 30000 && received < 1000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (issued >= 1000) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(2) == 0) begin
                    pa[i] = int'($urandom_range(255)); pb[i] = int'($urandom_range(255));
                    set_op(i, pa[i], pb[i]); req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(31) == 0) req_valid[i] = 1'b0;
            end
            rsp_ready = ($urandom_range(3) != 0);
            #1;
            exp_oh = '0;
            if (!inflight) begin
                for (int k = N-1; k >= 0; k--) begin
                    j = (ptr_m + k) % N;
                    if (req_valid[j]) exp_oh = N'(1) << j;
                end
            end
            total++; if (req_ready !== exp_oh) begin bad++; $display("FAIL rnd_grant c=%0d got=%b want=%b", c, req_ready, exp_oh); end
            total++; if (rsp_valid !== (inflight && age >= 2)) begin bad++; $display("FAIL rnd_rsp_valid c=%0d got=%b want=%b", c, rsp_valid, inflight && age >= 2); end
            if (rsp_valid && rsp_ready) begin
                total++;
                if (q.size() == 0) begin bad++; $display("FAIL rnd_spurious c=%0d id=%0d y=%0d", c, rsp_id, rsp_y); end
                else begin
                    e = q.pop_front();
                    if (rsp_id !== 3'(e.id) || rsp_y !== 16'(e.prod) || e.seq != rseq[e.id]) begin
                        bad++; $display("FAIL rnd_rsp c=%0d id=%0d y=%0d want %0d/%0d seq=%0d/%0d", c, rsp_id, rsp_y, e.id, e.prod, e.seq, rseq[e.id]);
                    end
                    rseq[e.id]++;
                end
                received++;
                inflight = 1'b0;
            end
            hsv = req_valid & req_ready;
            if (hsv != '0) begin
                g = 0;
                for (int i = 0; i < N; i++) if (hsv[i]) g = i;
                e.id = g; e.prod = pa[g] * pb[g]; e.seq = iseq[g];
                iseq[g]++;
                q.push_back(e);
                ptr_m = (g + 1) % N;
                inflight = 1'b1; age = 0; issued++;
            end
            tick;
            age++;
            req_valid = req_valid & ~hsv;
        end
        total++; if (received != 1000 || issued != 1000 || q.size() != 0) begin
            bad++; $display("FAIL rnd_totals issued=%0d received=%0d left=%0d want 1000/1000/0", issued, received, q.size()); end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick; tick; tick;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_reset_mid;
        test_corners;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
